// File: rtl/seq_add_sub_if.sv
// Start/result bundle for the multi-cycle adder/subtractor.
// The master drives the operands; the slave returns the result and handshake status.
interface seq_add_sub_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport master (
    output start, a, b, c_in, sub,
    input  ready, done, sum, c_out, ovf
  );

  modport slave (
    input  start, a, b, c_in, sub,
    output ready, done, sum, c_out, ovf
  );
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock through a narrow ripple slice,
// then registered sum, carry-out and signed overflow with a one-cycle done pulse.
module seq_add_sub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic         clk,
  input logic         rst_n,
  seq_add_sub_if.slave bus
);

  localparam int unsigned NChunk = WIDTH / CHUNK;
  localparam int unsigned IdxW   = (NChunk > 1) ? $clog2(NChunk) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NChunk - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
  logic             carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d, done_q, done_d;
  logic [CHUNK:0]   slice;
  logic             msb_cin;

  // Operands shift right one chunk per cycle, so the active slice always sits at bit 0.
  assign slice   = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
  // Carry into the slice's top bit, recovered from its sum bit and operand bits.
  assign msb_cin = slice[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {WIDTH{bus.sub}};
          carry_d = bus.c_in ^ bus.sub;
          idx_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        // Result slices enter at the top and settle into place after NChunk shifts.
        acc_d   = (acc_q >> CHUNK) | (WIDTH'(slice[CHUNK-1:0]) << (WIDTH - CHUNK));
        carry_d = slice[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          sum_d   = acc_d;
          c_out_d = slice[CHUNK];
          ovf_d   = msb_cin ^ slice[CHUNK];
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.ready = (state_q != StRun);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench for seq_add_sub: a 16/4 and an 8/2 instance, checked against
// a plain-integer arithmetic model with exact done timing.
module tb_seq_add_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    int unsigned cyc;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
  } exp_t;

  exp_t q16[$];
  exp_t q8[$];
  exp_t e16, e8;

  seq_add_sub_if #(.WIDTH(16)) if16 ();
  seq_add_sub_if #(.WIDTH(8))  if8 ();

  seq_add_sub #(.WIDTH(16), .CHUNK(4)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));
  seq_add_sub #(.WIDTH(8),  .CHUNK(2)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: whole-word integer arithmetic, signed range test for overflow.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic cin, input logic sb);
    exp_t   e;
    longint m, ua, ub, sa, sbv, full, sres;
    m   = longint'(1) << w;
    ua  = longint'({48'd0, av}) % m;
    ub  = longint'({48'd0, bv}) % m;
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (!sb) begin
      full    = ua + ub + longint'(cin);
      sres    = sa + sbv + longint'(cin);
      e.c_out = (full >= m);
    end else begin
      full    = ua - ub - longint'(cin);
      sres    = sa - sbv - longint'(cin);
      e.c_out = (full >= 0);
    end
    e.sum = 16'(((full % m) + m) % m);
    e.ovf = (sres >= m / 2) || (sres < -(m / 2));
    e.cyc = 0;
    e.a   = av;
    e.b   = bv;
    e.cin = cin;
    e.sub = sb;
    return e;
  endfunction

  always @(negedge clk) begin
    if (if16.done === 1'b1) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done16_unexpected actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e16 = q16.pop_front();
        chk($sformatf("sum16 a=%h b=%h cin=%b sub=%b", e16.a, e16.b, e16.cin, e16.sub),
            32'(if16.sum), 32'(e16.sum));
        chk("c_out16", 32'(if16.c_out), 32'(e16.c_out));
        chk("ovf16", 32'(if16.ovf), 32'(e16.ovf));
        chk("done16_cycle", cyc, e16.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (if8.done === 1'b1) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done8_unexpected actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e8 = q8.pop_front();
        chk($sformatf("sum_cout8 a=%h b=%h cin=%b sub=%b", e8.a[7:0], e8.b[7:0], e8.cin, e8.sub),
            32'({if8.c_out, if8.sum}), 32'({e8.c_out, e8.sum[7:0]}));
        chk("ovf8", 32'(if8.ovf), 32'(e8.ovf));
        chk("done8_cycle", cyc, e8.cyc);
      end
    end
  end

  // Waits for ready (optionally scrambling inputs meanwhile), then issues one operation.
  task automatic issue(input bit sel, input logic [15:0] av, input logic [15:0] bv,
                       input logic cin, input logic sb, input bit scramble);
    int unsigned n;
    exp_t        e;
    n = 0;
    @(negedge clk);
    while (!(sel ? if8.ready : if16.ready)) begin
      if (scramble) begin
        if (sel) begin
          if8.start = 1'($urandom); if8.a = 8'($urandom); if8.b = 8'($urandom);
          if8.c_in = 1'($urandom); if8.sub = 1'($urandom);
        end else begin
          if16.start = 1'($urandom); if16.a = 16'($urandom); if16.b = 16'($urandom);
          if16.c_in = 1'($urandom); if16.sub = 1'($urandom);
        end
      end
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL ready_timeout sel=%0d actual=0 required=1", sel);
        return;
      end
      @(negedge clk);
    end
    e     = model(sel ? 8 : 16, av, bv, cin, sb);
    e.cyc = cyc + 5;
    if (sel) begin
      if8.start = 1'b1; if8.a = av[7:0]; if8.b = bv[7:0]; if8.c_in = cin; if8.sub = sb;
      q8.push_back(e);
    end else begin
      if16.start = 1'b1; if16.a = av; if16.b = bv; if16.c_in = cin; if16.sub = sb;
      q16.push_back(e);
    end
    @(negedge clk);
    if8.start  = 1'b0;
    if16.start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((q16.size() != 0 || q8.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", 32'(q16.size() + q8.size()), 32'd0);
  endtask

  task automatic chk_idle16(input string tag);
    chk({tag, "_ready16"}, 32'(if16.ready), 32'd1);
    chk({tag, "_done16"}, 32'(if16.done), 32'd0);
    chk({tag, "_sum16"}, 32'(if16.sum), 32'd0);
    chk({tag, "_cout16"}, 32'(if16.c_out), 32'd0);
    chk({tag, "_ovf16"}, 32'(if16.ovf), 32'd0);
  endtask

  logic [7:0] corners [6];

  initial begin
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};
    if16.start = 1'b0; if16.a = '0; if16.b = '0; if16.c_in = 1'b0; if16.sub = 1'b0;
    if8.start  = 1'b0; if8.a  = '0; if8.b  = '0; if8.c_in  = 1'b0; if8.sub  = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_idle16("por");
    chk("por_ready8", 32'(if8.ready), 32'd1);

    // Directed cases, issued back to back.
    issue(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    issue(0, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    issue(0, 16'd5, 16'd7, 1'b0, 1'b1, 1'b0);
    issue(0, 16'd5, 16'd7, 1'b1, 1'b1, 1'b0);
    drain();

    // Inputs thrashed (including start) while the previous operation runs.
    issue(0, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0);
    issue(0, 16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 1'b1);
    issue(0, 16'h0F0F, 16'hF0F1, 1'b1, 1'b1, 1'b1);
    drain();

    // Reset mid-RUN discards the operation and clears the results.
    @(negedge clk);
    if16.start = 1'b1; if16.a = 16'h1234; if16.b = 16'h1111; if16.c_in = 1'b0; if16.sub = 1'b0;
    @(negedge clk);
    if16.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_idle16("rst");
    repeat (8) @(negedge clk);
    chk("rst_post_done16", 32'(if16.done), 32'd0);

    for (int i = 0; i < 400; i++) begin
      issue(0, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    for (int i = 0; i < 6; i++) begin
      for (int j = 0; j < 6; j++) begin
        for (int k = 0; k < 4; k++) begin
          issue(1, {8'd0, corners[i]}, {8'd0, corners[j]}, k[0], k[1], 1'b0);
        end
      end
    end
    for (int i = 0; i < 1500 && errors == 0; i++) begin
      issue(1, 16'($urandom_range(255)), 16'($urandom_range(255)), 1'($urandom), 1'($urandom),
            1'($urandom));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
